// File: rtl/kogge_stone_adder_pipe_if.sv
// Valid/ready operand and result channels of the pipelined Kogge-Stone adder.
// The master is the issuing/consuming side and the slave is the adder.
interface kogge_stone_adder_pipe_if #(
   parameter int WIDTH = 12,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
   );
endinterface

// File: rtl/kogge_stone_adder_pipe.sv
// Fully pipelined Kogge-Stone adder/subtractor with carry-in, signed overflow and a
// sideband tag; one register per prefix level plus input and result stages.
module kogge_stone_adder_pipe #(
   parameter int WIDTH = 12,
   parameter int TAG_W = 4
) (
   input logic                     clk,
   input logic                     rst,
   kogge_stone_adder_pipe_if.slave io_bus
);
   localparam int LEVELS = $clog2(WIDTH);

   logic             w_advance;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_c0;

   logic [WIDTH-1:0] r_g   [0:LEVELS];
   logic [WIDTH-1:0] r_p   [0:LEVELS];
   logic [WIDTH-1:0] r_po  [0:LEVELS];
   logic [TAG_W-1:0] r_tag [0:LEVELS];
   logic [LEVELS:0]  r_c0;
   logic [LEVELS:0]  r_vld;

   logic [WIDTH-1:0] w_g [1:LEVELS];
   logic [WIDTH-1:0] w_p [1:LEVELS];

   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic             w_ovf;

   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic [TAG_W-1:0] r_out_tag;
   logic             r_out_vld;

   // One prefix level of span 2^(k-1); carry-in enters as a generate below bit 0 on the first level.
   function automatic logic [2*WIDTH-1:0] prefix_level(
      input logic [WIDTH-1:0] g,
      input logic [WIDTH-1:0] p,
      input logic             c0,
      input int               k
   );
      logic [WIDTH-1:0] g_in;
      logic [WIDTH-1:0] g_o;
      logic [WIDTH-1:0] p_o;
      int               d;
      d    = 1 << (k - 1);
      g_in = g;
      if (k == 1) begin
         g_in[0] = g[0] | (p[0] & c0);
      end
      g_o = g_in;
      p_o = p;
      for (int i = 0; i < WIDTH; i++) begin
         if (i >= d) begin
            g_o[i] = g_in[i] | (p[i] & g_in[i-d]);
            p_o[i] = p[i] & p[i-d];
         end
      end
      return {g_o, p_o};
   endfunction

   // Carries into each bit are the final group generates shifted up by one.
   function automatic logic [WIDTH+1:0] final_stage(
      input logic [WIDTH-1:0] g,
      input logic [WIDTH-1:0] po,
      input logic             c0
   );
      logic [WIDTH-1:0] c;
      logic             cout;
      c    = {g[WIDTH-2:0], c0};
      cout = g[WIDTH-1];
      return {c[WIDTH-1] ^ cout, cout, po ^ c};
   endfunction

   always_comb begin
      w_advance = ~r_out_vld | io_bus.out_ready;
      w_b_eff   = io_bus.in_sub ? ~io_bus.in_b : io_bus.in_b;
      w_c0      = io_bus.in_sub ? ~io_bus.in_cin : io_bus.in_cin;
      w_g       = '{default: '0};
      w_p       = '{default: '0};
      for (int k = 1; k <= LEVELS; k++) begin
         {w_g[k], w_p[k]} = prefix_level(r_g[k-1], r_p[k-1], r_c0[k-1], k);
      end
      {w_ovf, w_cout, w_sum} = final_stage(r_g[LEVELS], r_po[LEVELS], r_c0[LEVELS]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld     <= '0;
         r_c0      <= '0;
         for (int k = 0; k <= LEVELS; k++) begin
            r_g[k]   <= '0;
            r_p[k]   <= '0;
            r_po[k]  <= '0;
            r_tag[k] <= '0;
         end
         r_sum     <= '0;
         r_cout    <= 1'b0;
         r_ovf     <= 1'b0;
         r_out_tag <= '0;
         r_out_vld <= 1'b0;
      end else if (w_advance) begin
         // Stage 0: per-bit propagate/generate of the prepared operands
         r_vld[0] <= io_bus.in_valid;
         r_g[0]   <= io_bus.in_a & w_b_eff;
         r_p[0]   <= io_bus.in_a ^ w_b_eff;
         r_po[0]  <= io_bus.in_a ^ w_b_eff;
         r_c0[0]  <= w_c0;
         r_tag[0] <= io_bus.in_tag;
         // Prefix levels 1..LEVELS
         for (int k = 1; k <= LEVELS; k++) begin
            r_vld[k] <= r_vld[k-1];
            r_g[k]   <= w_g[k];
            r_p[k]   <= w_p[k];
            r_po[k]  <= r_po[k-1];
            r_c0[k]  <= r_c0[k-1];
            r_tag[k] <= r_tag[k-1];
         end
         // Result stage
         r_sum     <= w_sum;
         r_cout    <= w_cout;
         r_ovf     <= w_ovf;
         r_out_tag <= r_tag[LEVELS];
         r_out_vld <= r_vld[LEVELS];
      end
   end

   assign io_bus.in_ready  = w_advance;
   assign io_bus.out_valid = r_out_vld;
   assign io_bus.out_sum   = r_sum;
   assign io_bus.out_cout  = r_cout;
   assign io_bus.out_ovf   = r_ovf;
   assign io_bus.out_tag   = r_out_tag;

endmodule

// File: tb/tb_kogge_stone_adder_pipe.sv
// Self-checking bench: directed WIDTH=12 cases plus concurrent random sweeps over several widths,
// all compared against an arithmetic reference model.
module tb_kogge_stone_adder_pipe;
   localparam int TW = 4;
   localparam int NB = 10000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_sw = 1'b1;
   int   n_checks = 0;
   int   n_errs = 0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns {ovf, cout, sum} for a w-bit add/subtract, from plain integer arithmetic.
   function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                         input logic cin, input logic sub);
      logic [67:0]        ua, ub, uc, full, mask;
      logic signed [67:0] sa, sb, sc, rs, smax, smin;
      logic               cout, ovf;
      mask = (68'd1 << w) - 68'd1;
      ua   = {4'd0, a} & mask;
      ub   = {4'd0, b} & mask;
      uc   = {67'd0, cin};
      full = sub ? (ua - ub - uc) : (ua + ub + uc);
      cout = sub ? (ua >= ub + uc) : full[w];
      sa   = ua[w-1] ? $signed(ua - (mask + 68'd1)) : $signed(ua);
      sb   = ub[w-1] ? $signed(ub - (mask + 68'd1)) : $signed(ub);
      sc   = $signed(uc);
      rs   = sub ? (sa - sb - sc) : (sa + sb + sc);
      smax = $signed(mask >> 1);
      smin = -smax - 68'sd1;
      ovf  = (rs > smax) || (rs < smin);
      return {ovf, cout, full[63:0] & mask[63:0]};
   endfunction

   kogge_stone_adder_pipe_if #(.WIDTH(12), .TAG_W(TW)) dif ();
   kogge_stone_adder_pipe #(.WIDTH(12), .TAG_W(TW)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (dif.slave)
   );

   // Random sweep, one independent DUT per width.
   for (genvar gi = 0; gi < 5; gi++) begin : g_sw
      localparam int W = (gi == 0) ? 2 : (gi == 1) ? 5 : (gi == 2) ? 12 : (gi == 3) ? 32 : 64;
      logic done = 1'b0;
      kogge_stone_adder_pipe_if #(.WIDTH(W), .TAG_W(TW)) sif ();
      kogge_stone_adder_pipe #(.WIDTH(W), .TAG_W(TW)) u_sw (
         .clk    (clk),
         .rst    (rst_sw),
         .io_bus (sif.slave)
      );

      initial begin
         logic [TW+65:0] q[$];
         logic [TW+65:0] e;
         logic [63:0]    ra, rb;
         logic           full, hv;
         logic [W+TW+1:0] hval;
         int sent, got, stall, cyc;
         sent = 0; got = 0; stall = 0; cyc = 0; hv = 1'b0; hval = '0;
         sif.in_valid = 1'b0; sif.in_a = '0; sif.in_b = '0; sif.in_cin = 1'b0;
         sif.in_sub = 1'b0; sif.in_tag = '0; sif.out_ready = 1'b0;
         while (rst_sw) @(posedge clk);
         while (got < NB && cyc < 70000) begin
            @(posedge clk);
            #1;
            full          = (sent >= NB - 200);
            ra            = {$urandom, $urandom};
            rb            = {$urandom, $urandom};
            sif.in_valid  = (sent < NB) && (full || ($urandom_range(3) != 0));
            sif.in_a      = ra[W-1:0];
            sif.in_b      = rb[W-1:0];
            sif.in_cin    = 1'($urandom_range(1));
            sif.in_sub    = 1'($urandom_range(1));
            sif.in_tag    = sent[TW-1:0];
            sif.out_ready = full || ($urandom_range(3) != 0);
            @(negedge clk);
            cyc++;
            if (hv) check($sformatf("w%0d_hold", W),
                          {sif.out_tag, sif.out_ovf, sif.out_cout, sif.out_sum}, hval);
            hv   = sif.out_valid && !sif.out_ready;
            hval = {sif.out_tag, sif.out_ovf, sif.out_cout, sif.out_sum};
            if (full && sif.in_valid && !sif.in_ready) stall++;
            if (sif.in_valid && sif.in_ready) begin
               q.push_back({sif.in_tag, model(W, ra, rb, sif.in_cin, sif.in_sub)});
               sent++;
            end
            if (sif.out_valid) begin
               if (q.size() == 0) begin
                  check($sformatf("w%0d_stale", W), 1, 0);
               end else if (sif.out_ready) begin
                  e = q.pop_front();
                  check($sformatf("w%0d_res", W), {sif.out_ovf, sif.out_cout, sif.out_sum}, e[W+1:0] | {e[65:64], {W{1'b0}}});
                  check($sformatf("w%0d_tag", W), sif.out_tag, e[TW+65:66]);
                  got++;
               end
            end
         end
         check($sformatf("w%0d_count", W), got, NB);
         check($sformatf("w%0d_left", W), q.size(), 0);
         check($sformatf("w%0d_fullrate_stalls", W), stall, 0);
         sif.in_valid = 1'b0;
         done = 1'b1;
      end
   end

   logic [4:0] w_done;
   assign w_done = {g_sw[4].done, g_sw[3].done, g_sw[2].done, g_sw[1].done, g_sw[0].done};

   int d_tag = 0;

   // Single beat on an empty pipe: checks latency and result fields.
   task automatic run_one(input string name, input logic [11:0] a, input logic [11:0] b,
                          input logic cin, input logic sub,
                          input logic [11:0] es, input logic ec, input logic eo);
      int n;
      dif.in_a = a; dif.in_b = b; dif.in_cin = cin; dif.in_sub = sub;
      dif.in_tag = d_tag[TW-1:0]; dif.in_valid = 1'b1; dif.out_ready = 1'b1;
      @(posedge clk);
      #1;
      dif.in_valid = 1'b0;
      n = 1;
      while (n < 20) begin
         @(negedge clk);
         if (dif.out_valid) break;
         @(posedge clk);
         n++;
      end
      check({name, "_lat"}, n, 6);
      check({name, "_sum"}, dif.out_sum, es);
      check({name, "_cout"}, dif.out_cout, ec);
      check({name, "_ovf"}, dif.out_ovf, eo);
      check({name, "_tag"}, dif.out_tag, d_tag[TW-1:0]);
      d_tag++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [TW+65:0] bq[$];
      logic [TW+65:0] e;
      logic [63:0]    ra, rb;
      logic [11:0]    hs;
      logic           hv;
      int sent, got, stale, waitc;
      dif.in_valid = 1'b0; dif.in_a = '0; dif.in_b = '0; dif.in_cin = 1'b0;
      dif.in_sub = 1'b0; dif.in_tag = '0; dif.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      rst_sw = 1'b0;
      @(negedge clk);
      check("rst_out_valid", dif.out_valid, 0);
      check("rst_out_sum", dif.out_sum, 0);
      check("rst_out_cout", dif.out_cout, 0);
      check("rst_out_ovf", dif.out_ovf, 0);
      check("rst_out_tag", dif.out_tag, 0);
      check("rst_in_ready", dif.in_ready, 1);
      @(posedge clk);
      #1;

      run_one("wrap",    12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
      run_one("posovf",  12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1);
      run_one("subneg",  12'h005, 12'h007, 1'b0, 1'b1, 12'hFFE, 1'b0, 1'b0);
      run_one("subovf",  12'h800, 12'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1);
      run_one("cin",     12'h0FF, 12'h000, 1'b1, 1'b0, 12'h100, 1'b0, 1'b0);
      run_one("borrow",  12'h010, 12'h001, 1'b1, 1'b1, 12'h00E, 1'b1, 1'b0);

      // Backpressure: ten back-to-back beats, out_ready low in cycles 8..10.
      sent = 0; got = 0; hv = 1'b0; hs = '0;
      for (int c = 0; c < 40; c++) begin
         ra = {32'd0, $urandom};
         rb = {32'd0, $urandom};
         dif.out_ready = !(c >= 8 && c <= 10);
         dif.in_valid  = (sent < 10);
         dif.in_a = ra[11:0]; dif.in_b = rb[11:0];
         dif.in_cin = 1'($urandom_range(1)); dif.in_sub = 1'($urandom_range(1));
         dif.in_tag = sent[TW-1:0];
         @(negedge clk);
         if (c < 16) check($sformatf("bp_in_ready_c%0d", c), dif.in_ready, (c >= 8 && c <= 10) ? 0 : 1);
         if (hv) check("bp_hold_sum", dif.out_sum, hs);
         hv = dif.out_valid && !dif.out_ready;
         hs = dif.out_sum;
         if (dif.in_valid && dif.in_ready) begin
            bq.push_back({dif.in_tag, model(12, ra, rb, dif.in_cin, dif.in_sub)});
            sent++;
         end
         if (dif.out_valid && dif.out_ready) begin
            if (bq.size() == 0) begin
               check("bp_stale", 1, 0);
            end else begin
               e = bq.pop_front();
               check("bp_res", {dif.out_ovf, dif.out_cout, dif.out_sum}, {e[65:64], e[11:0]});
               check("bp_tag", dif.out_tag, got);
               got++;
            end
         end
         @(posedge clk);
         #1;
      end
      check("bp_count", got, 10);

      // Reset with four beats in flight.
      dif.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dif.in_valid = 1'b1;
         dif.in_a = 12'($urandom); dif.in_b = 12'($urandom);
         dif.in_tag = 4'(i + 3);
         @(posedge clk);
         #1;
      end
      dif.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mrst_out_valid", dif.out_valid, 0);
      check("mrst_out_sum", dif.out_sum, 0);
      check("mrst_in_ready", dif.in_ready, 1);
      stale = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (dif.out_valid) stale++;
      end
      check("mrst_stale", stale, 0);

      waitc = 0;
      while (w_done != 5'h1F && waitc < 80000) begin
         @(posedge clk);
         waitc++;
      end
      check("sweep_done", w_done, 5'h1F);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule
